// File: rtl/coef_high_mult.sv
// High-band coefficient multiplier: 16-tap sample delay line scaled by 8-bit
// coefficient magnitudes through one shared multiplier. Optional: COEF_HIGH_OVERRUN_EN.
module coef_high_mult (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample_in,
  input  logic        sample_rdy,
  input  logic        coe_we,
  input  logic [3:0]  coe_addr,
  input  logic [7:0]  coe_data,
  output logic [16:0] outHIGH0,
  output logic [16:0] outHIGH1,
  output logic [16:0] outHIGH2,
  output logic [16:0] outHIGH3,
  output logic [16:0] outHIGH4,
  output logic [16:0] outHIGH5,
  output logic [16:0] outHIGH6,
  output logic [16:0] outHIGH7,
  output logic [16:0] outHIGH8,
  output logic [16:0] outHIGH9,
  output logic [16:0] outHIGH10,
  output logic [16:0] outHIGH11,
  output logic [16:0] outHIGH12,
  output logic [16:0] outHIGH13,
  output logic [16:0] outHIGH14,
  output logic [16:0] outHIGH15,
  output logic        RDYcoeHigh,
  output logic        busy,
`ifdef COEF_HIGH_OVERRUN_EN
  output logic        overrun,
`endif
  output logic [1:0]  state_dbg
);

  // Handshake: sample_rdy is a one-cycle strobe taken only in IDLE (never
  // back-pressured, dropped while busy); RDYcoeHigh is a one-cycle strobe
  // marking all sixteen products valid, with no ready from downstream.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sample_q, sample_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] taps_q [16];
  logic [15:0] taps_d [16];
  logic [7:0]  coef_q [16];
  logic [7:0]  coef_d [16];
  logic [16:0] out_q  [16];
  logic [16:0] out_d  [16];

  logic [23:0] mac_full;
  logic [16:0] mac_prod;

  // 65535*255 fits in 24 bits; dropping the 7 fraction bits leaves 17.
  assign mac_full = {8'd0, taps_q[idx_q]} * {16'd0, coef_q[idx_q]};
  assign mac_prod = 17'(mac_full >> 7);

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    idx_d    = idx_q;
    taps_d   = taps_q;
    coef_d   = coef_q;
    out_d    = out_q;

    if ((state_q == IDLE) && coe_we) begin
      coef_d[coe_addr] = coe_data;
    end

    case (state_q)
      IDLE: begin
        if (sample_rdy) begin
          sample_d = sample_in;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        for (int k = 1; k < 16; k++) begin
          taps_d[k] = taps_q[k-1];
        end
        taps_d[0] = sample_q;
        idx_d     = 4'd0;
        state_d   = MAC;
      end
      MAC: begin
        out_d[idx_q] = mac_prod;
        idx_d        = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sample_q <= '0;
      idx_q    <= '0;
      for (int k = 0; k < 16; k++) begin
        taps_q[k] <= '0;
        coef_q[k] <= 8'd128;
        out_q[k]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      taps_q   <= taps_d;
      coef_q   <= coef_d;
      out_q    <= out_d;
    end
  end

`ifdef COEF_HIGH_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Clear code is a zero written to coefficient 15 while idle.
  always_comb begin
    overrun_d = overrun_q;
    if ((state_q != IDLE) && sample_rdy) begin
      overrun_d = 1'b1;
    end else if ((state_q == IDLE) && coe_we && (coe_addr == 4'd15) && (coe_data == 8'd0)) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

  assign RDYcoeHigh = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

  assign outHIGH0  = out_q[0];
  assign outHIGH1  = out_q[1];
  assign outHIGH2  = out_q[2];
  assign outHIGH3  = out_q[3];
  assign outHIGH4  = out_q[4];
  assign outHIGH5  = out_q[5];
  assign outHIGH6  = out_q[6];
  assign outHIGH7  = out_q[7];
  assign outHIGH8  = out_q[8];
  assign outHIGH9  = out_q[9];
  assign outHIGH10 = out_q[10];
  assign outHIGH11 = out_q[11];
  assign outHIGH12 = out_q[12];
  assign outHIGH13 = out_q[13];
  assign outHIGH14 = out_q[14];
  assign outHIGH15 = out_q[15];

endmodule

// File: tb/tb_coef_high_mult.sv
// Directed bench for coef_high_mult: latency, scaling, delay line, dropped
// samples, coefficient write gating and mid-computation reset.
module tb_coef_high_mult;

  logic        clk;
  logic        rst_n;
  logic [15:0] sample_in;
  logic        sample_rdy;
  logic        coe_we;
  logic [3:0]  coe_addr;
  logic [7:0]  coe_data;
  logic [16:0] out_h [16];
  logic        rdy;
  logic        busy;
  logic [1:0]  state_dbg;
`ifdef COEF_HIGH_OVERRUN_EN
  logic        overrun;
`endif

  int checks;
  int failures;
  int cnt;

  coef_high_mult dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_in  (sample_in),
    .sample_rdy (sample_rdy),
    .coe_we     (coe_we),
    .coe_addr   (coe_addr),
    .coe_data   (coe_data),
    .outHIGH0   (out_h[0]),
    .outHIGH1   (out_h[1]),
    .outHIGH2   (out_h[2]),
    .outHIGH3   (out_h[3]),
    .outHIGH4   (out_h[4]),
    .outHIGH5   (out_h[5]),
    .outHIGH6   (out_h[6]),
    .outHIGH7   (out_h[7]),
    .outHIGH8   (out_h[8]),
    .outHIGH9   (out_h[9]),
    .outHIGH10  (out_h[10]),
    .outHIGH11  (out_h[11]),
    .outHIGH12  (out_h[12]),
    .outHIGH13  (out_h[13]),
    .outHIGH14  (out_h[14]),
    .outHIGH15  (out_h[15]),
    .RDYcoeHigh (rdy),
    .busy       (busy),
`ifdef COEF_HIGH_OVERRUN_EN
    .overrun    (overrun),
`endif
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [15:0] v);
    sample_in  = v;
    sample_rdy = 1'b1;
    tick();
    sample_rdy = 1'b0;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
    coe_we   = 1'b1;
    coe_addr = a;
    coe_data = d;
    tick();
    coe_we   = 1'b0;
  endtask

  // Called in the cycle after an accepted strobe; counts cycles to RDYcoeHigh.
  task automatic wait_rdy(input string tag, input int exp_cycles);
    cnt = 0;
    while (!rdy && cnt < 40) begin
      tick();
      cnt++;
    end
    check({tag, "_latency"}, cnt, exp_cycles);
    check({tag, "_busy_at_rdy"}, {31'd0, busy}, 1);
    tick();
    check({tag, "_rdy_single"}, {31'd0, rdy}, 0);
    check({tag, "_idle_after"}, {31'd0, busy}, 0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    sample_in  = '0;
    sample_rdy = 1'b0;
    coe_we     = 1'b0;
    coe_addr   = '0;
    coe_data   = '0;
    repeat (3) tick();

    // reset state
    check("rst_rdy", {31'd0, rdy}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    for (int k = 0; k < 16; k++) check($sformatf("rst_out%0d", k), {15'd0, out_h[k]}, 0);
`ifdef COEF_HIGH_OVERRUN_EN
    check("rst_overrun", {31'd0, overrun}, 0);
`endif
    rst_n = 1'b1;
    tick();

    // single sample, unity coefficients
    send(16'd1000);
    check("t1_busy_n1", {31'd0, busy}, 1);
    check("t1_rdy_n1", {31'd0, rdy}, 0);
    wait_rdy("t1", 17);
    check("t1_out0", {15'd0, out_h[0]}, 1000);
    for (int k = 1; k < 16; k++) check($sformatf("t1_out%0d", k), {15'd0, out_h[k]}, 0);

    // full-scale product, no wrap
    write_coef(4'd0, 8'd255);
    send(16'd65535);
    wait_rdy("t2", 17);
    check("t2_out0", {15'd0, out_h[0]}, 130558);
    check("t2_out1", {15'd0, out_h[1]}, 1000);
    write_coef(4'd0, 8'd128);

    // delay line ordering: 17 samples, 20 cycles apart
    for (int s = 1; s <= 17; s++) begin
      send(16'(s));
      wait_rdy($sformatf("t3_s%0d", s), 17);
      tick();
    end
    for (int k = 0; k < 16; k++) check($sformatf("t3_out%0d", k), {15'd0, out_h[k]}, 32'(17 - k));

    // dropped sample at N+5 and ignored coefficient write at N+4
    send(16'd500);
    repeat (3) tick();
    coe_we   = 1'b1;
    coe_addr = 4'd3;
    coe_data = 8'd64;
    tick();
    coe_we     = 1'b0;
    sample_in  = 16'd9999;
    sample_rdy = 1'b1;
    tick();
    sample_rdy = 1'b0;
`ifdef COEF_HIGH_OVERRUN_EN
    check("t4_overrun_set", {31'd0, overrun}, 1);
`endif
    check("t4_busy_n6", {31'd0, busy}, 1);
    wait_rdy("t4", 12);
    check("t4_out0", {15'd0, out_h[0]}, 500);
    check("t4_out3_coef_ignored", {15'd0, out_h[3]}, 15);
    send(16'd700);
    wait_rdy("t4b", 17);
    check("t4b_out0", {15'd0, out_h[0]}, 700);
    check("t4b_out1_no_9999", {15'd0, out_h[1]}, 500);
    check("t4b_out2", {15'd0, out_h[2]}, 17);
    check("t4b_out3", {15'd0, out_h[3]}, 16);
`ifdef COEF_HIGH_OVERRUN_EN
    check("t4b_overrun_sticky", {31'd0, overrun}, 1);
`endif

    // coefficient write in IDLE, then write coincident with the strobe
    write_coef(4'd3, 8'd64);
    send(16'd800);
    wait_rdy("t5", 17);
    check("t5_out0", {15'd0, out_h[0]}, 800);
    check("t5_out3_half", {15'd0, out_h[3]}, 8);
    coe_we   = 1'b1;
    coe_addr = 4'd0;
    coe_data = 8'd255;
    send(16'd256);
    coe_we = 1'b0;
    wait_rdy("t6", 17);
    check("t6_out0_same_cycle", {15'd0, out_h[0]}, 510);
    check("t6_out3", {15'd0, out_h[3]}, 250);
    check("t6_out1", {15'd0, out_h[1]}, 800);

`ifdef COEF_HIGH_OVERRUN_EN
    write_coef(4'd15, 8'd0);
    check("t7_overrun_clr", {31'd0, overrun}, 0);
    write_coef(4'd15, 8'd128);
`endif

    // reset mid-MAC at N+10
    send(16'd1234);
    repeat (9) tick();
    check("t8_busy_n10", {31'd0, busy}, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t8_rst_rdy", {31'd0, rdy}, 0);
    check("t8_rst_busy", {31'd0, busy}, 0);
    for (int k = 0; k < 16; k++) check($sformatf("t8_rst_out%0d", k), {15'd0, out_h[k]}, 0);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (rdy) cnt++;
      tick();
    end
    check("t8_no_rdy_after_rst", cnt, 0);
    send(16'd100);
    wait_rdy("t8", 17);
    check("t8_out0_coef_reset", {15'd0, out_h[0]}, 100);
    check("t8_out1_taps_reset", {15'd0, out_h[1]}, 0);
    check("t8_out3_taps_reset", {15'd0, out_h[3]}, 0);
`ifdef COEF_HIGH_OVERRUN_EN
    check("t8_overrun", {31'd0, overrun}, 0);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
